// File: rtl/simple_fifo_unpacker.sv
// simple_fifo_unpacker: wide-to-narrow FWFT FIFO, least-significant slice first
module simple_fifo_unpacker #(
   parameter int DATA_IN_WIDTH  = 128,
   parameter int DATA_OUT_WIDTH = 16,
   parameter int ADDR_WIDTH     = 8,
   parameter int FULL_SLACK     = 1,
   parameter int USE_LAST       = 0
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      wr_ena,
   input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
   input  logic                      wr_last,
   output logic                      wr_full,
   input  logic                      rd_ena,
   output logic [DATA_OUT_WIDTH-1:0] rd_dat,
   output logic                      rd_last,
   output logic                      rd_empty,
   output logic [ADDR_WIDTH:0]       wr_dat_cnt
);
   localparam int R     = DATA_IN_WIDTH / DATA_OUT_WIDTH;
   localparam int IW    = $clog2(R);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int EW    = DATA_IN_WIDTH + ((USE_LAST != 0) ? 1 : 0);
   localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   FULL_TH  = (ADDR_WIDTH+1)'(DEPTH - FULL_SLACK);
   localparam logic [ADDR_WIDTH:0]   ONE_C    = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
   localparam logic [IW-1:0]         LAST_IDX = IW'(R - 1);
   localparam logic [IW-1:0]         IDX_ONE  = IW'(1);

   typedef enum logic {EMPTY, VALID} state_t;

   state_t                  state, state_nxt;
   logic [EW-1:0]           mem [DEPTH];
   logic [EW-1:0]           wr_word, rd_word;
   logic                    rd_word_last;
   logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]     count, count_nxt;
   logic [IW-1:0]           idx, idx_nxt;
   logic [DATA_IN_WIDTH-1:0] hold_dat;
   logic                    hold_last;
   logic                    hold_vld;
   logic                    wr_acc, adv, pop;

   if (DATA_IN_WIDTH % DATA_OUT_WIDTH != 0 || R < 2 || (R & (R - 1)) != 0) begin : g_bad_ratio
      $error("DATA_IN_WIDTH must be DATA_OUT_WIDTH times a power of two >= 2");
   end

   if (USE_LAST != 0) begin : g_last
      assign wr_word      = {wr_last, wr_dat};
      assign rd_word_last = rd_word[EW-1];
   end else begin : g_nolast
      logic unused_last;
      assign unused_last  = wr_last;
      assign wr_word      = wr_dat;
      assign rd_word_last = 1'b0;
   end

   assign rd_word = mem[rd_ptr];

   // acceptance, pop and next-state decisions, all from pre-edge state
   always_comb begin
      wr_acc    = wr_ena && (count != DEPTH_C);
      adv       = hold_vld && rd_ena;
      pop       = (count != '0) && (!hold_vld || (adv && idx == LAST_IDX));
      state_nxt = pop ? VALID : (adv && idx == LAST_IDX) ? EMPTY : state;
      count_nxt = (wr_acc && !pop) ? count + ONE_C : (pop && !wr_acc) ? count - ONE_C : count;
      idx_nxt   = pop ? '0 : adv ? idx + IDX_ONE : idx;
   end

   // output state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= EMPTY;
      else       state <= state_nxt;
   end

   // pointers, occupancy, slice index and holding register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         idx       <= '0;
         hold_dat  <= '0;
         hold_last <= 1'b0;
      end else begin
         count <= count_nxt;
         idx   <= idx_nxt;
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            hold_dat  <= rd_word[DATA_IN_WIDTH-1:0];
            hold_last <= rd_word_last;
         end
      end
   end

   // storage array, left unreset since it is only read when count says it is valid
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_word;
   end

   assign hold_vld   = (state == VALID);
   assign rd_dat     = hold_dat[idx*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
   assign rd_empty   = !hold_vld;
   assign rd_last    = hold_vld && hold_last && (idx == LAST_IDX);
   assign wr_full    = (count >= FULL_TH);
   assign wr_dat_cnt = count;
endmodule

// File: tb/tb_simple_fifo_unpacker.sv
// tb_simple_fifo_unpacker: scoreboard bench for the wide-to-narrow FIFO
module tb_simple_fifo_unpacker;
   logic         clk = 1'b0, rstn = 1'b1;
   logic         wr_ena = 1'b0, wr_last = 1'b0, rd_ena = 1'b0;
   logic [127:0] wr_dat = '0;
   logic         wr_full, rd_last, rd_empty;
   logic [15:0]  rd_dat;
   logic [3:0]   wr_dat_cnt;
   int           checks = 0, failures = 0;
   logic [16:0]  sb [$];
   logic         wdone;

   always #5 clk = ~clk;

   simple_fifo_unpacker #(
      .DATA_IN_WIDTH(128), .DATA_OUT_WIDTH(16), .ADDR_WIDTH(3), .FULL_SLACK(2), .USE_LAST(1)
   ) dut (
      .clk(clk), .rstn(rstn), .wr_ena(wr_ena), .wr_dat(wr_dat), .wr_last(wr_last),
      .wr_full(wr_full), .rd_ena(rd_ena), .rd_dat(rd_dat), .rd_last(rd_last),
      .rd_empty(rd_empty), .wr_dat_cnt(wr_dat_cnt)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] mkword(input logic [7:0] tag);
      logic [127:0] w;
      for (int j = 0; j < 8; j++) w[j*16 +: 16] = {tag, 8'(j)};
      return w;
   endfunction

   task automatic push_word(input logic [7:0] tag, input logic last);
      for (int j = 0; j < 8; j++) sb.push_back({last && (j == 7), tag, 8'(j)});
   endtask

   task automatic wr(input logic [127:0] d, input logic l);
      wr_ena = 1'b1; wr_dat = d; wr_last = l;
      @(posedge clk); #1;
      wr_ena = 1'b0; wr_last = 1'b0;
   endtask

   task automatic drain(input string nm);
      for (int n = 0; n < 200 && sb.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      chk(nm, 128'(sb.size()), 0);
      chk({nm, "_empty"}, rd_empty, 1'b1);
   endtask

   // monitor: every slice consumed on the coming edge must match the queue head
   always @(negedge clk) begin
      if (rstn && rd_ena && !rd_empty) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_slice got=%0h last=%0b exp=none", rd_dat, rd_last);
         end else begin
            chk("slice", {rd_last, rd_dat}, sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_cnt [10] = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};
      logic       exp_full[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
      #2 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", rd_empty, 1'b1);
      chk("rst_last", rd_last, 1'b0);
      chk("rst_dat", rd_dat, 16'h0);
      chk("rst_cnt", wr_dat_cnt, 4'd0);
      chk("rst_full", wr_full, 1'b0);
      rstn = 1'b1;
      @(posedge clk); #1;

      rd_ena = 1'b1;
      for (int j = 0; j < 8; j++) sb.push_back({1'b0, 16'(j)});
      wr(128'h0007_0006_0005_0004_0003_0002_0001_0000, 1'b0);
      chk("lat_cnt_T", wr_dat_cnt, 4'd1);
      chk("lat_empty_T", rd_empty, 1'b1);
      @(posedge clk); #1;
      chk("lat_empty_T1", rd_empty, 1'b0);
      chk("lat_cnt_T1", wr_dat_cnt, 4'd0);
      chk("lat_dat_T1", rd_dat, 16'h0000);
      repeat (8) begin @(posedge clk); #1; end
      chk("single_done_empty", rd_empty, 1'b1);
      chk("single_done_sb", 128'(sb.size()), 0);

      push_word(8'h01, 1'b0); push_word(8'h02, 1'b0); push_word(8'h03, 1'b1);
      wr(mkword(8'h01), 1'b0);
      wr(mkword(8'h02), 1'b0);
      wr(mkword(8'h03), 1'b1);
      repeat (22) begin @(posedge clk); #1; end
      chk("b2b_slice24_last", rd_last, 1'b1);
      chk("b2b_slice24_dat", rd_dat, 16'h0307);
      @(posedge clk); #1;
      chk("b2b_done_empty", rd_empty, 1'b1);

      rd_ena = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k < 9) push_word(8'(8'h10 + k), 1'b0);
         wr(mkword(8'(8'h10 + k)), 1'b0);
         chk($sformatf("fill_cnt_%0d", k + 1), wr_dat_cnt, exp_cnt[k]);
         chk($sformatf("fill_full_%0d", k + 1), wr_full, exp_full[k]);
      end
      rd_ena = 1'b1;
      drain("fill_drain");
      chk("fill_drain_cnt", wr_dat_cnt, 4'd0);
      chk("fill_drain_full", wr_full, 1'b0);
      rd_ena = 1'b0;

      wdone = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               for (int n = 0; n < 100 && wr_full; n++) begin @(posedge clk); #1; end
               push_word(8'(8'h40 + i), (i % 5) == 4);
               wr(mkword(8'(8'h40 + i)), (i % 5) == 4);
            end
            wdone = 1'b1;
         end
         begin
            for (int n = 0; n < 3000; n++) begin
               if (wdone && sb.size() == 0) break;
               rd_ena = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
               chk("stream_cnt_le_depth", wr_dat_cnt <= 4'd8, 1'b1);
            end
            rd_ena = 1'b0;
         end
      join
      chk("stream_drained", 128'(sb.size()), 0);
      chk("stream_empty", rd_empty, 1'b1);

      push_word(8'h70, 1'b0);
      wr(mkword(8'h70), 1'b0);
      wr(mkword(8'h71), 1'b0);
      rd_ena = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      rd_ena = 1'b0;
      chk("midword_dat", rd_dat, 16'h7003);
      chk("midword_cnt", wr_dat_cnt, 4'd1);
      #2 rstn = 1'b0;
      #1;
      chk("async_rst_empty", rd_empty, 1'b1);
      chk("async_rst_dat", rd_dat, 16'h0);
      chk("async_rst_cnt", wr_dat_cnt, 4'd0);
      chk("async_rst_last", rd_last, 1'b0);
      sb.delete();
      #2 rstn = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_empty", rd_empty, 1'b1);
      chk("post_rst_cnt", wr_dat_cnt, 4'd0);
      rd_ena = 1'b1;
      push_word(8'h80, 1'b1);
      wr(mkword(8'h80), 1'b1);
      drain("post_rst_drain");

      repeat (5) begin @(posedge clk); #1; end
      chk("rd_on_empty_empty", rd_empty, 1'b1);
      chk("rd_on_empty_cnt", wr_dat_cnt, 4'd0);
      push_word(8'h90, 1'b0);
      wr(mkword(8'h90), 1'b0);
      drain("rd_on_empty_drain");
      rd_ena = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
